// File: rtl/fir_xifu_regfile_sb.sv
// -----------------------------------------------------------------------------
// fir_xifu_regfile_sb
//
// Multi-port register file for the FIR XIFU with an integrated scoreboard.
// EX reads operands combinationally and allocates destination registers
// (marking them busy). WB writes results back, which releases the busy bit.
// EX stalls on a read whose operand is still busy (RAW). It also cannot
// allocate a destination that is already busy (WAW).
//
// Parameters
//   NB_REGS      number of registers (>= 2)
//   DATA_WIDTH   register width
//   NB_RD_PORTS  number of combinational read ports
//   NB_WR_PORTS  number of write ports; a higher index wins on collisions
//   BYPASS       1 = same-cycle write data is forwarded to the read ports
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   rd_addr_i      read addresses, port p at slice p
//   rd_data_o      read data, port p at slice p
//   rd_busy_o      per read port: operand not yet available
//   alloc_valid_i  EX requests busy marking of alloc_rd_i
//   alloc_rd_i     destination register to allocate
//   alloc_ready_o  allocation accepted this cycle
//   wr_valid_i     write enables, one per write port
//   wr_addr_i      write addresses, port j at slice j
//   wr_data_i      write data, port j at slice j
//   clear_i        synchronous flush of all busy bits
//   busy_o         scoreboard state
//   err_o          registered one-cycle pulse after a write-port collision
// -----------------------------------------------------------------------------
module fir_xifu_regfile_sb #(
    parameter int  NB_REGS     = 8,
    parameter int  DATA_WIDTH  = 32,
    parameter int  NB_RD_PORTS = 3,
    parameter int  NB_WR_PORTS = 2,
    parameter int  BYPASS      = 1,
    localparam int AW          = $clog2(NB_REGS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NB_RD_PORTS*AW-1:0]         rd_addr_i,
    output logic [NB_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
    output logic [NB_RD_PORTS-1:0]            rd_busy_o,
    input  logic                              alloc_valid_i,
    input  logic [AW-1:0]                     alloc_rd_i,
    output logic                              alloc_ready_o,
    input  logic [NB_WR_PORTS-1:0]            wr_valid_i,
    input  logic [NB_WR_PORTS*AW-1:0]         wr_addr_i,
    input  logic [NB_WR_PORTS*DATA_WIDTH-1:0] wr_data_i,
    input  logic                              clear_i,
    output logic [NB_REGS-1:0]                busy_o,
    output logic                              err_o
);

    // One extra bit so that NB_REGS itself is representable for the range test.
    localparam logic [AW:0] REG_LIMIT = (AW + 1)'(NB_REGS);

    logic [DATA_WIDTH-1:0] regs_r [NB_REGS];
    logic [NB_REGS-1:0]    busy_r;
    logic                  err_r;

    logic [NB_REGS-1:0]    wr_hit_s;
    logic [DATA_WIDTH-1:0] wr_merge_s [NB_REGS];
    logic                  collision_s;
    logic                  alloc_in_range_s;
    logic                  alloc_release_s;
    logic                  alloc_ready_s;
    logic                  alloc_fire_s;
    logic [NB_REGS-1:0]    busy_next_s;

    // Addresses beyond the last register exist when NB_REGS is not a power of two.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < REG_LIMIT);
    endfunction

    // Per-register write resolution: later (higher-index) ports override earlier ones.
    always_comb begin
        for (int r = 0; r < NB_REGS; r++) begin
            wr_hit_s[r]   = 1'b0;
            wr_merge_s[r] = '0;
            for (int j = 0; j < NB_WR_PORTS; j++) begin
                logic match_s;
                match_s       = wr_valid_i[j] && (wr_addr_i[j*AW +: AW] == AW'(r));
                wr_hit_s[r]   = wr_hit_s[r] | match_s;
                wr_merge_s[r] = match_s ? wr_data_i[j*DATA_WIDTH +: DATA_WIDTH] : wr_merge_s[r];
            end
        end
    end

    // Two valid ports targeting the same real register is a collision.
    always_comb begin
        collision_s = 1'b0;
        for (int i = 0; i < NB_WR_PORTS; i++) begin
            for (int j = i + 1; j < NB_WR_PORTS; j++) begin
                collision_s = collision_s
                            | (wr_valid_i[i] & wr_valid_i[j]
                               & (wr_addr_i[i*AW +: AW] == wr_addr_i[j*AW +: AW])
                               & addr_in_range(wr_addr_i[i*AW +: AW]));
            end
        end
    end

    // Read ports: range check, optional forwarding from the write ports, then array.
    for (genvar p = 0; p < NB_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0]         addr_s;
        logic                  hit_s;
        logic [DATA_WIDTH-1:0] fwd_s;
        logic [DATA_WIDTH-1:0] data_s;
        logic                  busy_s;

        assign addr_s = rd_addr_i[p*AW +: AW];

        // Forwarding candidate: the highest-index valid write to this address.
        always_comb begin
            hit_s = 1'b0;
            fwd_s = '0;
            for (int j = 0; j < NB_WR_PORTS; j++) begin
                logic match_s;
                match_s = wr_valid_i[j] && (wr_addr_i[j*AW +: AW] == addr_s);
                hit_s   = hit_s | match_s;
                fwd_s   = match_s ? wr_data_i[j*DATA_WIDTH +: DATA_WIDTH] : fwd_s;
            end
        end

        // Operand select; a forwarded operand is by definition available.
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            if (!addr_in_range(addr_s)) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if ((BYPASS != 0) && hit_s) begin
                data_s = fwd_s;
                busy_s = 1'b0;
            end else begin
                data_s = regs_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data_s;
        assign rd_busy_o[p]                          = busy_s;
    end

    // Allocation handshake: a busy destination may be reused only when it is
    // being released this cycle or the whole scoreboard is flushed.
    always_comb begin
        alloc_in_range_s = addr_in_range(alloc_rd_i);
        if (alloc_in_range_s) begin
            alloc_release_s = wr_hit_s[alloc_rd_i];
            alloc_ready_s   = ~busy_r[alloc_rd_i] | alloc_release_s | clear_i;
        end else begin
            alloc_release_s = 1'b0;
            alloc_ready_s   = 1'b1;
        end
        alloc_fire_s = alloc_valid_i & alloc_in_range_s & alloc_ready_s;
    end

    // Scoreboard next state: flush, then allocate, then release, else hold.
    always_comb begin
        busy_next_s = busy_r;
        for (int r = 0; r < NB_REGS; r++) begin
            if (clear_i) begin
                busy_next_s[r] = 1'b0;
            end else if (alloc_fire_s && (alloc_rd_i == AW'(r))) begin
                busy_next_s[r] = 1'b1;
            end else if (wr_hit_s[r]) begin
                busy_next_s[r] = 1'b0;
            end else begin
                busy_next_s[r] = busy_r[r];
            end
        end
    end

    // State registers: data array, scoreboard and collision flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NB_REGS; r++) begin
                regs_r[r] <= '0;
            end
            busy_r <= '0;
            err_r  <= 1'b0;
        end else begin
            for (int r = 0; r < NB_REGS; r++) begin
                if (wr_hit_s[r]) begin
                    regs_r[r] <= wr_merge_s[r];
                end else begin
                    regs_r[r] <= regs_r[r];
                end
            end
            busy_r <= busy_next_s;
            err_r  <= collision_s;
        end
    end

    assign alloc_ready_o = alloc_ready_s;
    assign busy_o        = busy_r;
    assign err_o         = err_r;

endmodule

// File: doc/fir_xifu_regfile_sb.md
Name: fir_xifu_regfile_sb

Overview:
Parametrised multi-port register file for the FIR XIFU with an integrated scoreboard. It provides NB_RD_PORTS combinational read ports with optional WB-to-EX bypass, and NB_WR_PORTS write ports. Per-register busy bits track pending writebacks, so EX can stall on RAW and WAW hazards. It sits between the EX stage (read/allocate) and the WB stage (write/release).

Parameters:
NB_REGS, 8, number of registers (>=2); AW = $clog2(NB_REGS)
DATA_WIDTH, 32, register width in bits
NB_RD_PORTS, 3, number of read ports (op_a, op_b, op_c by default)
NB_WR_PORTS, 2, number of write ports; higher index has priority
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = no forwarding

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
rd_addr_i  in  NB_RD_PORTS*AW  read addresses, port p at slice p
rd_data_o  out  NB_RD_PORTS*DATA_WIDTH  read data
rd_busy_o  out  NB_RD_PORTS  read operand not yet available (EX must stall)
alloc_valid_i  in  1  EX issues an instruction that will write alloc_rd_i
alloc_rd_i  in  AW  destination register to mark busy
alloc_ready_o  out  1  allocation accepted this cycle
wr_valid_i  in  NB_WR_PORTS  write enables
wr_addr_i  in  NB_WR_PORTS*AW  write addresses
wr_data_i  in  NB_WR_PORTS*DATA_WIDTH  write data
clear_i  in  1  synchronous flush of all busy bits
busy_o  out  NB_REGS  scoreboard state
err_o  out  1  write-port collision flag, registered

Behaviour:
- Reset (rst_i=1, asynchronous): all registers = 0, busy = 0, err_o = 0. Outputs are then combinational from that state, so rd_data_o = 0, rd_busy_o = 0 and alloc_ready_o = 1.
- Reads are combinational, zero latency.
  - An address >= NB_REGS returns 0 with rd_busy = 0.
- BYPASS=1:
  - If any wr_valid port j has wr_addr[j] == rd_addr[p], rd_data[p] = wr_data of the highest matching j.
  - rd_busy[p] = busy[rd_addr[p]] & ~hit.
- BYPASS=0:
  - rd_data[p] = regs[rd_addr[p]].
  - rd_busy[p] = busy[rd_addr[p]]; a same-cycle write is visible on the next cycle.
- Writes take effect at the clock edge.
  - Writes to addresses >= NB_REGS are ignored.
  - Writes to non-busy registers are legal and update the data.
  - If several ports hit the same address, the highest index wins and err_o = 1 on the following cycle only (1-cycle pulse); otherwise err_o = 0.
- Busy bit update per register r, in priority order:
  1. clear_i -> 0.
  2. Else accepted alloc to r -> 1.
  3. Else any valid write to r -> 0.
  4. Else hold.
- alloc_ready_o = ~busy[alloc_rd] | (write to alloc_rd this cycle) | clear_i. This blocks WAW reallocation until release.
  - A simultaneous release and alloc to the same register leaves busy = 1.
  - alloc_rd >= NB_REGS: alloc_ready_o = 1, no state change.
- clear_i does not affect register contents or in-flight writes; data writes in the clear cycle still commit.
- Reset asserted mid-operation aborts everything: data, busy and err all return to 0 immediately.
- Datapath widths are exact; there is no sign extension or truncation.

Test Plan:
- Reset, then read all ports at r0..r2 -> rd_data = 0, rd_busy = 0, busy_o = 0, alloc_ready_o = 1, err_o = 0.
- Alloc r3 (accepted), next cycle read r3 -> rd_busy = 1; alloc r3 again -> alloc_ready_o = 0. Then wr port0 r3 = 0xDEADBEEF, reading r3 the same cycle:
  - BYPASS=1 -> rd_data = 0xDEADBEEF, rd_busy = 0.
  - BYPASS=0 -> rd_busy = 1, rd_data = old value.
  - Next cycle, both modes -> busy[3] = 0, rd_data = 0xDEADBEEF.
- Both write ports hit r5 (port0 = 0x11, port1 = 0x22) in one cycle -> r5 = 0x22, err_o = 1 for exactly one cycle, then 0.
- Alloc r2 while WB writes r2 (busy) the same cycle -> alloc_ready_o = 1, busy[2] stays 1; a later write to r2 -> busy[2] = 0.
- Busy r1, r4; assert clear_i with alloc r6 and wr r4 = 0x7 -> busy_o = 0, r4 = 0x7.
- Mid-sequence rst_i pulse between clock edges -> all registers and busy bits read 0 immediately, without waiting for the clock edge.
